// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues one word request at a time to
// instruction memory, and presents PC_4 / Instrucction / if_valid to IF/ID.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_4,
  output logic [31:0] Instrucction,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_FULL
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        kill_q, kill_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] fetch_pc4;
  logic        new_word;
  logic [31:0] new_instr;
  logic [31:0] new_pc4;

  assign redirect  = branch_taken | jump;
  assign target    = branch_taken ? branch_target : jump_target;
  assign fetch_pc4 = fetch_pc_q + 32'd4;

  // Gate with rst_n so no request is presented while reset is held.
  assign imem_req     = rst_n && (state_q == S_ISSUE);
  assign imem_addr    = pc_q;
  assign PC_4         = pc4_q;
  assign Instrucction = instr_q;
  assign if_valid     = valid_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    kill_d       = kill_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    new_word     = 1'b0;
    new_instr    = 32'h0;
    new_pc4      = 32'h0;

    unique case (state_q)
      S_ISSUE: begin
        if (imem_ready) begin
          fetch_pc_d = pc_q;
          state_d    = S_WAIT;
          // Accepted request for the old pc is already in flight; discard it.
          if (redirect) kill_d = 1'b1;
        end
        if (redirect) pc_d = target;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_ISSUE;
          kill_d  = 1'b0;
          if (redirect) begin
            pc_d = target;
          end else if (!kill_q) begin
            pc_d = fetch_pc4;
            if (stall) begin
              skid_valid_d = 1'b1;
              skid_instr_d = imem_rdata;
              skid_pc4_d   = fetch_pc4;
              state_d      = S_FULL;
            end else begin
              new_word  = 1'b1;
              new_instr = imem_rdata;
              new_pc4   = fetch_pc4;
            end
          end
        end else if (redirect) begin
          kill_d = 1'b1;
          pc_d   = target;
        end
      end
      S_FULL: begin
        if (redirect) begin
          skid_valid_d = 1'b0;
          pc_d         = target;
          state_d      = S_ISSUE;
        end else if (!stall) begin
          new_word     = 1'b1;
          new_instr    = skid_instr_q;
          new_pc4      = skid_pc4_q;
          skid_valid_d = 1'b0;
          state_d      = S_ISSUE;
        end
      end
      default: state_d = S_ISSUE;
    endcase

    // Output slot: redirect bubbles (even under stall), stall holds, else load or bubble.
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (redirect) begin
      instr_d = 32'h0;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (new_word) begin
        instr_d = new_instr;
        pc4_d   = new_pc4;
        valid_d = 1'b1;
      end else begin
        instr_d = 32'h0;
        valid_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_ISSUE;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      kill_q       <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc4_q   <= 32'h0;
      pc4_q        <= 32'h0;
      instr_q      <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      kill_q       <= kill_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      pc4_q        <= pc4_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: inputs change and outputs are sampled 1ns
// after each rising edge; expected values are hand-computed constants.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC_4;
  logic [31:0] Instrucction;
  logic        if_valid;

  int total = 0;
  int bad   = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .PC_4         (PC_4),
    .Instrucction (Instrucction),
    .if_valid     (if_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One straight-line fetch: request at addr, accepted at once, data next cycle.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] pc4);
    chk("fetch_req", {31'h0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, addr);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("wait_req", {31'h0, imem_req}, 32'd0);
    chk("wait_bubble_valid", {31'h0, if_valid}, 32'd0);
    chk("wait_bubble_instr", Instrucction, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    chk("out_instr", Instrucction, data);
    chk("out_pc4", PC_4, pc4);
    chk("out_valid", {31'h0, if_valid}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc4", PC_4, 32'h0);
    chk("rst_instr", Instrucction, 32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;

    // First fetch after reset, then straight-line run.
    fetch(32'h0, 32'h2008_0005, 32'd4);
    chk("next_addr", imem_addr, 32'd4);
    fetch(32'h4, 32'h2009_0001, 32'd8);
    fetch(32'h8, 32'h0128_5020, 32'd12);
    fetch(32'hC, 32'hAC0A_0000, 32'd16);

    // Stall for 3 edges: request accepted, response lands in skid (FULL).
    stall = 1'b1;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("stall1_instr", Instrucction, 32'hAC0A_0000);
    chk("stall1_valid", {31'h0, if_valid}, 32'd1);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    chk("stall2_instr", Instrucction, 32'hAC0A_0000);
    chk("stall2_pc4", PC_4, 32'd16);
    chk("full_req", {31'h0, imem_req}, 32'd0);
    tick();
    chk("stall3_instr", Instrucction, 32'hAC0A_0000);
    chk("full_req2", {31'h0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    chk("drain_instr", Instrucction, 32'h1234_5678);
    chk("drain_pc4", PC_4, 32'd20);
    chk("drain_valid", {31'h0, if_valid}, 32'd1);
    chk("drain_addr", imem_addr, 32'd20);
    chk("drain_req", {31'h0, imem_req}, 32'd1);

    // Reset mid-request, then a stray rvalid after release.
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'h0, imem_req}, 32'd0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_instr", Instrucction, 32'h0);
    chk("midrst_valid", {31'h0, if_valid}, 32'd0);
    chk("midrst_pc4", PC_4, 32'h0);
    tick();
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    tick();
    imem_rvalid = 1'b0;
    chk("stray_instr", Instrucction, 32'h0);
    chk("stray_valid", {31'h0, if_valid}, 32'd0);
    chk("stray_addr", imem_addr, 32'h0);
    chk("stray_req", {31'h0, imem_req}, 32'd1);
    fetch(32'h0, 32'h2008_0005, 32'd4);
    fetch(32'h4, 32'h2009_0001, 32'd8);

    // Branch in the same cycle the request for 0x8 is accepted.
    imem_ready    = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    tick();
    imem_ready   = 1'b0;
    branch_taken = 1'b0;
    chk("br_bubble_valid", {31'h0, if_valid}, 32'd0);
    chk("br_bubble_instr", Instrucction, 32'h0);
    chk("br_bubble_pc4", PC_4, 32'd8);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("br_drop_valid", {31'h0, if_valid}, 32'd0);
    chk("br_drop_instr", Instrucction, 32'h0);
    fetch(32'h40, 32'h0800_0020, 32'h44);

    // Branch has priority over a simultaneous jump.
    branch_taken  = 1'b1; branch_target = 32'h80;
    jump          = 1'b1; jump_target   = 32'h100;
    tick();
    branch_taken = 1'b0; jump = 1'b0;
    chk("prio_addr", imem_addr, 32'h80);
    chk("prio_valid", {31'h0, if_valid}, 32'd0);
    fetch(32'h80, 32'h0000_0020, 32'h84);

    // Jump while waiting, response dropped; then PC wraps at the top.
    imem_ready = 1'b1;
    tick();
    imem_ready  = 1'b0;
    jump        = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    chk("jw_req", {31'h0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    tick();
    imem_rvalid = 1'b0;
    chk("jw_drop_valid", {31'h0, if_valid}, 32'd0);
    fetch(32'hFFFF_FFFC, 32'h2222_2222, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
